// File: rtl/keypoint_finder_if.sv
// Memory-side bus of the keypoint finder.
// Carries the six Gaussian-level read ports (two octaves x three levels) and the
// keypoint BRAM write port.
//   master : used by keypoint_finder (drives addresses and keypoint writes, takes read data)
//   slave  : used by the memory side (drives read data, takes addresses and writes)
interface keypoint_finder_if #(
    parameter int DIMENSION = 64,
    parameter int BIT_DEPTH = 8
);
    localparam int L  = $clog2(DIMENSION);
    localparam int A1 = $clog2(DIMENSION * DIMENSION);
    localparam int A2 = $clog2((DIMENSION / 2) * (DIMENSION / 2));

    logic signed [BIT_DEPTH-1:0] O1L1_data, O1L2_data, O1L3_data;
    logic signed [BIT_DEPTH-1:0] O2L1_data, O2L2_data, O2L3_data;
    logic [A1-1:0]               O1L1_read_addr, O1L2_read_addr, O1L3_read_addr;
    logic [A2-1:0]               O2L1_read_addr, O2L2_read_addr, O2L3_read_addr;
    logic [A1-1:0]               key_write_addr;
    logic                        key_wea;
    logic [2*L:0]                keypoint_out;

    modport master (
        input  O1L1_data, O1L2_data, O1L3_data, O2L1_data, O2L2_data, O2L3_data,
        output O1L1_read_addr, O1L2_read_addr, O1L3_read_addr,
        output O2L1_read_addr, O2L2_read_addr, O2L3_read_addr,
        output key_write_addr, key_wea, keypoint_out
    );

    modport slave (
        output O1L1_data, O1L2_data, O1L3_data, O2L1_data, O2L2_data, O2L3_data,
        input  O1L1_read_addr, O1L2_read_addr, O1L3_read_addr,
        input  O2L1_read_addr, O2L2_read_addr, O2L3_read_addr,
        input  key_write_addr, key_wea, keypoint_out
    );
endinterface

// File: rtl/keypoint_finder.sv
// Scale-space extremum detector. Scans the interior of both octaves, forms the
// DoG samples L1-L2 and L2-L3 from 2-cycle-latency BRAM reads, and writes every
// strict 3x3x2 extremum of the L1-L2 layer as {x, y, octave} into the keypoint BRAM.
//   clk, rst_in (sync, active-low), start (one-cycle pulse, honoured in idle/done)
//   bus              : level read ports and keypoint write port (master side)
//   O1_DOG_L2L3_done : one-cycle pulse after the octave-1 scan
//   keypoints_done   : high once both octaves have been scanned
module keypoint_finder #(
    parameter int DIMENSION = 64,
    parameter int BIT_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst_in,
    input  logic              start,
    keypoint_finder_if.master bus,
    output logic              O1_DOG_L2L3_done,
    output logic              keypoints_done
);
    localparam int L  = $clog2(DIMENSION);
    localparam int A1 = $clog2(DIMENSION * DIMENSION);
    localparam int DW = BIT_DEPTH + 1;
    localparam logic [L-1:0] LastO1 = L'(DIMENSION - 2);
    localparam logic [L-1:0] LastO2 = L'(DIMENSION / 2 - 2);

    typedef enum logic [1:0] {StIdle, StO1Scan, StO2Scan, StDone} state_e;

    state_e          state_q, state_d;
    logic [3:0]      phase_q, phase_d;
    logic [L-1:0]    row_q, row_d, col_q, col_d;
    logic [A1-1:0]   count_q, count_d;
    logic            o1_done_q, o1_done_d;

    logic signed [DW-1:0] d1_q [9];
    logic signed [DW-1:0] d2_q [9];
    logic signed [DW-1:0] d1_new, d2_new;
    logic [BIT_DEPTH-1:0] l1, l2, l3;

    logic            scanning, oct2, capture, is_max, is_min, hit;
    logic [L-1:0]    last, row_n, col_n;
    logic [1:0]      dy, dx;

    assign scanning = (state_q == StO1Scan) || (state_q == StO2Scan);
    assign oct2     = (state_q == StO2Scan);
    assign last     = oct2 ? LastO2 : LastO1;

    // Data for the address issued at phase p arrives at phase p+2.
    assign capture  = scanning && (phase_q >= 4'd2) && (phase_q <= 4'd10);

    assign l1 = oct2 ? bus.O2L1_data : bus.O1L1_data;
    assign l2 = oct2 ? bus.O2L2_data : bus.O1L2_data;
    assign l3 = oct2 ? bus.O2L3_data : bus.O1L3_data;

    // One extra sign bit keeps the differences exact.
    assign d1_new = {l1[BIT_DEPTH-1], l1} - {l2[BIT_DEPTH-1], l2};
    assign d2_new = {l2[BIT_DEPTH-1], l2} - {l3[BIT_DEPTH-1], l3};

    // Neighbourhood offset for the address issued this phase (raster order).
    always_comb begin
        dy = 2'd0;
        dx = 2'd0;
        case (phase_q)
            4'd1: dx = 2'd1;
            4'd2: dx = 2'd2;
            4'd3: dy = 2'd1;
            4'd4: begin dy = 2'd1; dx = 2'd1; end
            4'd5: begin dy = 2'd1; dx = 2'd2; end
            4'd6: dy = 2'd2;
            4'd7: begin dy = 2'd2; dx = 2'd1; end
            4'd8: begin dy = 2'd2; dx = 2'd2; end
            default: ;
        endcase
    end

    assign row_n = row_q + L'(dy) - L'(1);
    assign col_n = col_q + L'(dx) - L'(1);

    always_comb begin
        bus.O1L1_read_addr = '0;
        bus.O1L2_read_addr = '0;
        bus.O1L3_read_addr = '0;
        bus.O2L1_read_addr = '0;
        bus.O2L2_read_addr = '0;
        bus.O2L3_read_addr = '0;
        if (phase_q <= 4'd8) begin
            if (state_q == StO1Scan) begin
                bus.O1L1_read_addr = {row_n, col_n};
                bus.O1L2_read_addr = {row_n, col_n};
                bus.O1L3_read_addr = {row_n, col_n};
            end else if (state_q == StO2Scan) begin
                bus.O2L1_read_addr = {row_n[L-2:0], col_n[L-2:0]};
                bus.O2L2_read_addr = {row_n[L-2:0], col_n[L-2:0]};
                bus.O2L3_read_addr = {row_n[L-2:0], col_n[L-2:0]};
            end
        end
    end

    // Shift register: after nine captures index 4 holds the centre sample.
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int i = 0; i < 8; i++) begin
                d1_q[i] <= d1_q[i+1];
                d2_q[i] <= d2_q[i+1];
            end
            d1_q[8] <= d1_new;
            d2_q[8] <= d2_new;
        end
    end

    // Strict extremum against 8 neighbouring d1 and all 9 d2; any tie disqualifies.
    always_comb begin
        is_max = 1'b1;
        is_min = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (i != 4) begin
                if (d1_q[i] >= d1_q[4]) is_max = 1'b0;
                if (d1_q[i] <= d1_q[4]) is_min = 1'b0;
            end
            if (d2_q[i] >= d1_q[4]) is_max = 1'b0;
            if (d2_q[i] <= d1_q[4]) is_min = 1'b0;
        end
    end

    assign hit = scanning && (phase_q == 4'd11) && (is_max || is_min);

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        row_d     = row_q;
        col_d     = col_q;
        count_d   = count_q;
        o1_done_d = 1'b0;
        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StO1Scan;
                    phase_d = 4'd0;
                    row_d   = L'(1);
                    col_d   = L'(1);
                    count_d = '0;
                end
            end
            StO1Scan, StO2Scan: begin
                if (hit) count_d = count_q + 1'b1;
                if (phase_q == 4'd11) begin
                    phase_d = 4'd0;
                    if (col_q == last) begin
                        col_d = L'(1);
                        if (row_q == last) begin
                            row_d = L'(1);
                            if (oct2) begin
                                state_d = StDone;
                            end else begin
                                state_d   = StO2Scan;
                                o1_done_d = 1'b1;
                            end
                        end else begin
                            row_d = row_q + 1'b1;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_in) begin
            state_q   <= StIdle;
            phase_q   <= 4'd0;
            row_q     <= L'(1);
            col_q     <= L'(1);
            count_q   <= '0;
            o1_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            row_q     <= row_d;
            col_q     <= col_d;
            count_q   <= count_d;
            o1_done_q <= o1_done_d;
        end
    end

    assign bus.key_wea        = hit;
    assign bus.key_write_addr = count_q;
    assign bus.keypoint_out   = hit ? {col_q, row_q, oct2} : '0;
    assign O1_DOG_L2L3_done   = o1_done_q;
    assign keypoints_done     = (state_q == StDone);
endmodule

// File: tb/tb_keypoint_finder.sv
module tb_keypoint_finder;
    localparam int D     = 32;
    localparam int D2    = D / 2;
    localparam int T_O1  = (D - 2) * (D - 2) * 12;     // 10800
    localparam int T_ALL = T_O1 + (D2 - 2) * (D2 - 2) * 12; // 13152
    localparam int T_HIT1 = ((10 - 1) * (D - 2) + (20 - 1)) * 12 + 11;         // (20,10) oct 1
    localparam int T_HIT2 = T_O1 + ((5 - 1) * (D2 - 2) + (7 - 1)) * 12 + 11;   // (7,5) oct 2

    logic clk = 1'b0;
    logic rst_in = 1'b0;
    logic start = 1'b0;
    logic o1_done, kp_done;

    keypoint_finder_if #(.DIMENSION(D), .BIT_DEPTH(8)) bus ();

    keypoint_finder #(.DIMENSION(D), .BIT_DEPTH(8)) dut (
        .clk              (clk),
        .rst_in           (rst_in),
        .start            (start),
        .bus              (bus),
        .O1_DOG_L2L3_done (o1_done),
        .keypoints_done   (kp_done)
    );

    always #5 clk = ~clk;

    // Level memories with 2-cycle read latency.
    logic signed [7:0] o1l1 [D*D], o1l2 [D*D], o1l3 [D*D];
    logic signed [7:0] o2l1 [D2*D2], o2l2 [D2*D2], o2l3 [D2*D2];
    logic signed [7:0] s11, s12, s13, s21, s22, s23;

    always @(posedge clk) begin
        s11 <= o1l1[bus.O1L1_read_addr]; bus.O1L1_data <= s11;
        s12 <= o1l2[bus.O1L2_read_addr]; bus.O1L2_data <= s12;
        s13 <= o1l3[bus.O1L3_read_addr]; bus.O1L3_data <= s13;
        s21 <= o2l1[bus.O2L1_read_addr]; bus.O2L1_data <= s21;
        s22 <= o2l2[bus.O2L2_read_addr]; bus.O2L2_data <= s22;
        s23 <= o2l3[bus.O2L3_read_addr]; bus.O2L3_data <= s23;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [10:0] wr_kp [$];
    logic [9:0]  wr_addr [$];
    int          wr_cyc [$];
    int          o1_pulses, o1_cyc, kd_cyc;
    bit          kd_seen, addr_seen;
    int          n_checks = 0;
    int          n_pass = 0;

    always @(negedge clk) begin
        if (bus.key_wea) begin
            wr_kp.push_back(bus.keypoint_out);
            wr_addr.push_back(bus.key_write_addr);
            wr_cyc.push_back(cyc);
        end
        if (o1_done) begin
            o1_pulses++;
            o1_cyc = cyc;
        end
        if (kp_done && !kd_seen) begin
            kd_seen = 1'b1;
            kd_cyc  = cyc;
        end
        if (bus.O1L1_read_addr != 0 || bus.O2L1_read_addr != 0) addr_seen = 1'b1;
    end

    task automatic clear_log();
        wr_kp.delete();
        wr_addr.delete();
        wr_cyc.delete();
        o1_pulses = 0;
        kd_seen   = 1'b0;
        addr_seen = 1'b0;
    endtask

    task automatic clear_mems();
        for (int i = 0; i < D * D; i++) begin
            o1l1[i] = 0; o1l2[i] = 0; o1l3[i] = 0;
        end
        for (int i = 0; i < D2 * D2; i++) begin
            o2l1[i] = 0; o2l2[i] = 0; o2l3[i] = 0;
        end
    endtask

    // Returns the cycle-counter value seen at scan cycle 0.
    task automatic pulse_start(output int sc);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        sc = cyc;
        clear_log();
    endtask

    task automatic wait_done();
        for (int i = 0; i < T_ALL + 200 && !kd_seen; i++) @(negedge clk);
        n_checks++;
        if (kd_seen !== 1'b1) $display("FAIL done_timeout: got %0b want 1", kd_seen);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_in = 1'b0;
        start  = 1'b1;  // must be ignored on the reset cycle
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (bus.key_wea !== 1'b0) $display("FAIL rst_wea: got %0b want 0", bus.key_wea); else n_pass++;
        n_checks++; if (kp_done !== 1'b0) $display("FAIL rst_kpdone: got %0b want 0", kp_done); else n_pass++;
        n_checks++; if (o1_done !== 1'b0) $display("FAIL rst_o1done: got %0b want 0", o1_done); else n_pass++;
        n_checks++; if (bus.key_write_addr !== 10'd0) $display("FAIL rst_waddr: got %0d want 0", bus.key_write_addr); else n_pass++;
        n_checks++; if (bus.keypoint_out !== 11'd0) $display("FAIL rst_kpout: got %0h want 0", bus.keypoint_out); else n_pass++;
        n_checks++; if (bus.O1L1_read_addr !== 10'd0 || bus.O2L3_read_addr !== 8'd0)
            $display("FAIL rst_raddr: got %0d/%0d want 0/0", bus.O1L1_read_addr, bus.O2L3_read_addr); else n_pass++;
        rst_in = 1'b1;
        start  = 1'b0;
        clear_log();
        repeat (40) @(negedge clk);
        n_checks++; if (addr_seen !== 1'b0) $display("FAIL idle_addr: got %0b want 0", addr_seen); else n_pass++;
        n_checks++; if (kp_done !== 1'b0) $display("FAIL idle_done: got %0b want 0", kp_done); else n_pass++;
    endtask

    task automatic test_all_zero();
        int sc;
        clear_mems();
        pulse_start(sc);
        wait_done();
        n_checks++; if (wr_kp.size() !== 0) $display("FAIL zero_writes: got %0d want 0", wr_kp.size()); else n_pass++;
        n_checks++; if (o1_pulses !== 1) $display("FAIL zero_o1_pulses: got %0d want 1", o1_pulses); else n_pass++;
        n_checks++; if (o1_cyc - sc !== T_O1) $display("FAIL zero_o1_time: got %0d want %0d", o1_cyc - sc, T_O1); else n_pass++;
        n_checks++; if (kd_cyc - sc !== T_ALL) $display("FAIL zero_done_time: got %0d want %0d", kd_cyc - sc, T_ALL); else n_pass++;
        n_checks++; if (bus.key_write_addr !== 10'd0) $display("FAIL zero_count: got %0d want 0", bus.key_write_addr); else n_pass++;
    endtask

    task automatic test_single_max();
        int sc;
        logic [10:0] e;
        e = {5'(20), 5'(10), 1'b0};
        clear_mems();
        o1l1[10*D + 20] = 8'sd50;
        pulse_start(sc);
        wait_done();
        n_checks++; if (wr_kp.size() !== 1) $display("FAIL single_writes: got %0d want 1", wr_kp.size()); else n_pass++;
        n_checks++; if (((wr_kp.size() > 0) ? wr_kp[0] : 11'bx) !== e)
            $display("FAIL single_kp: got %0h want %0h", (wr_kp.size() > 0) ? wr_kp[0] : 11'bx, e); else n_pass++;
        n_checks++; if (((wr_addr.size() > 0) ? wr_addr[0] : 10'bx) !== 10'd0)
            $display("FAIL single_addr: got %0d want 0", (wr_addr.size() > 0) ? wr_addr[0] : 10'bx); else n_pass++;
        n_checks++; if (((wr_cyc.size() > 0) ? wr_cyc[0] - sc : -1) !== T_HIT1)
            $display("FAIL single_time: got %0d want %0d", (wr_cyc.size() > 0) ? wr_cyc[0] - sc : -1, T_HIT1); else n_pass++;
        n_checks++; if (bus.key_write_addr !== 10'd1) $display("FAIL single_count: got %0d want 1", bus.key_write_addr); else n_pass++;
    endtask

    task automatic test_two_hits();
        int sc;
        logic [10:0] e0, e1;
        e0 = {5'(20), 5'(10), 1'b0};
        e1 = {5'(7), 5'(5), 1'b1};
        clear_mems();
        o1l1[10*D + 20] = -8'sd50;
        o2l1[5*D2 + 7]  = 8'sd30;
        pulse_start(sc);
        wait_done();
        n_checks++; if (wr_kp.size() !== 2) $display("FAIL two_writes: got %0d want 2", wr_kp.size()); else n_pass++;
        n_checks++; if (((wr_kp.size() > 0) ? wr_kp[0] : 11'bx) !== e0)
            $display("FAIL two_kp0: got %0h want %0h", (wr_kp.size() > 0) ? wr_kp[0] : 11'bx, e0); else n_pass++;
        n_checks++; if (((wr_addr.size() > 0) ? wr_addr[0] : 10'bx) !== 10'd0)
            $display("FAIL two_addr0: got %0d want 0", (wr_addr.size() > 0) ? wr_addr[0] : 10'bx); else n_pass++;
        n_checks++; if (((wr_kp.size() > 1) ? wr_kp[1] : 11'bx) !== e1)
            $display("FAIL two_kp1: got %0h want %0h", (wr_kp.size() > 1) ? wr_kp[1] : 11'bx, e1); else n_pass++;
        n_checks++; if (((wr_addr.size() > 1) ? wr_addr[1] : 10'bx) !== 10'd1)
            $display("FAIL two_addr1: got %0d want 1", (wr_addr.size() > 1) ? wr_addr[1] : 10'bx); else n_pass++;
        n_checks++; if (((wr_cyc.size() > 1) ? wr_cyc[1] - sc : -1) !== T_HIT2)
            $display("FAIL two_time1: got %0d want %0d", (wr_cyc.size() > 1) ? wr_cyc[1] - sc : -1, T_HIT2); else n_pass++;
        n_checks++; if (bus.key_write_addr !== 10'd2) $display("FAIL two_count: got %0d want 2", bus.key_write_addr); else n_pass++;
    endtask

    task automatic test_border_plateau();
        int sc;
        clear_mems();
        o1l1[5*D + 0]  = 8'sd100;
        o1l1[8*D + 12] = 8'sd40;
        o1l1[8*D + 13] = 8'sd40;
        pulse_start(sc);
        // Restart from DONE must drop done and clear the write address.
        n_checks++; if (kp_done !== 1'b0) $display("FAIL restart_done: got %0b want 0", kp_done); else n_pass++;
        n_checks++; if (bus.key_write_addr !== 10'd0) $display("FAIL restart_waddr: got %0d want 0", bus.key_write_addr); else n_pass++;
        wait_done();
        n_checks++; if (wr_kp.size() !== 0) $display("FAIL plateau_writes: got %0d want 0", wr_kp.size()); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int sc;
        logic [10:0] e;
        e = {5'(20), 5'(10), 1'b0};
        clear_mems();
        o1l1[10*D + 20] = 8'sd50;
        pulse_start(sc);
        repeat (T_HIT1 + 500) @(negedge clk);
        n_checks++; if (bus.key_write_addr !== 10'd1) $display("FAIL mid_pre_count: got %0d want 1", bus.key_write_addr); else n_pass++;
        @(posedge clk); #1 rst_in = 1'b0;
        @(posedge clk); #1;
        clear_log();
        n_checks++; if (bus.key_write_addr !== 10'd0) $display("FAIL mid_rst_waddr: got %0d want 0", bus.key_write_addr); else n_pass++;
        n_checks++; if (bus.O1L1_read_addr !== 10'd0) $display("FAIL mid_rst_raddr: got %0d want 0", bus.O1L1_read_addr); else n_pass++;
        repeat (3) @(posedge clk);
        #1 rst_in = 1'b1;
        repeat (T_HIT1 + 100) @(negedge clk);
        n_checks++; if (wr_kp.size() !== 0 || addr_seen !== 1'b0)
            $display("FAIL mid_after_rst: got writes=%0d addr=%0b want 0/0", wr_kp.size(), addr_seen); else n_pass++;
        pulse_start(sc);
        repeat (500) @(negedge clk);
        start = 1'b1;  // stray start while scanning
        @(negedge clk);
        start = 1'b0;
        wait_done();
        n_checks++; if (wr_kp.size() !== 1) $display("FAIL mid_writes: got %0d want 1", wr_kp.size()); else n_pass++;
        n_checks++; if (((wr_kp.size() > 0) ? wr_kp[0] : 11'bx) !== e)
            $display("FAIL mid_kp: got %0h want %0h", (wr_kp.size() > 0) ? wr_kp[0] : 11'bx, e); else n_pass++;
        n_checks++; if (((wr_addr.size() > 0) ? wr_addr[0] : 10'bx) !== 10'd0)
            $display("FAIL mid_addr: got %0d want 0", (wr_addr.size() > 0) ? wr_addr[0] : 10'bx); else n_pass++;
        n_checks++; if (((wr_cyc.size() > 0) ? wr_cyc[0] - sc : -1) !== T_HIT1)
            $display("FAIL mid_time: got %0d want %0d", (wr_cyc.size() > 0) ? wr_cyc[0] - sc : -1, T_HIT1); else n_pass++;
        n_checks++; if (kd_cyc - sc !== T_ALL) $display("FAIL mid_done_time: got %0d want %0d", kd_cyc - sc, T_ALL); else n_pass++;
    endtask

    initial begin
        clear_mems();
        clear_log();
        test_reset();
        test_all_zero();
        test_single_max();
        test_two_hits();
        test_border_plateau();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
